fp_add_controller: RTL and testbench

Control FSM for the floating-point add/subtract datapath: the side that drives the datapath's control inputs and reads back its status. It replaces the hand-sequenced stimulus currently used to operate the datapath. It runs one operation per `start`: exponent difference, operand alignment, significand add/subtract, normalization and rounding fix-up, with `load` pulses timed for the rounding register. It sits between the requesting logic (`start`/`done` handshake) and the datapath instance.

---
 rtl/fp_add_controller.sv | 207 ++++++++++++++++++++
 tb/tb_fp_add_controller.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_add_controller.sv
// Sequencing FSM for the floating-point add/subtract datapath: one operation per
// start (exponent, alignment, ALU, normalization, rounding fix-up) with load strobes.
module fp_add_controller (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        op_sub,
  input  logic [7:0]  saida_registrador,
  input  logic [25:0] data_out_big_ula,
  input  logic        overflow,
  output logic [4:0]  tamanho,
  output logic [4:0]  tamanho2,
  output logic [7:0]  tamanho3,
  output logic        soma_multiplica_small_ula,
  output logic        soma_multiplica_big_ula,
  output logic        decisor_mux_expoente_escolhido,
  output logic        decisor_mux_saida_big_ula,
  output logic        decisor_shift_right_left,
  output logic        subtrador_big_ula,
  output logic        subtrador_Somador_subtrador,
  output logic        load,
  output logic        busy,
  output logic        done,
  output logic        zero_result
);

  typedef enum logic [3:0] {
    S_IDLE, S_EXP, S_ALIGN, S_EXP_SET, S_EXP_LOAD, S_NORM_SET,
    S_NORM_LOAD, S_ROUND, S_FIX_SET, S_FIX_LOAD, S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  diff_q, diff_d;
  logic [25:0] big_q, big_d;
  logic [4:0]  lz_q, lz_d;
  logic        op_sub_q, op_sub_d;
  logic        zero_q, zero_d;
  logic [4:0]  tamanho2_q, tamanho2_d;
  logic [7:0]  tamanho3_q, tamanho3_d;
  logic        soma_q, soma_d;
  logic        mux_exp_q, mux_exp_d;
  logic        mux_saida_q, mux_saida_d;
  logic        dir_q, dir_d;
  logic        sub_exp_q, sub_exp_d;
  logic        load_q, load_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  function automatic logic [4:0] clz26(input logic [25:0] v);
    logic [4:0] n;
    logic       found;
    n     = 5'd26;
    found = 1'b0;
    for (int i = 25; i >= 0; i--) begin
      if (!found && v[i]) begin
        n     = 5'(25 - i);
        found = 1'b1;
      end
    end
    return n;
  endfunction

  always_comb begin
    state_d  = state_q;
    diff_d   = diff_q;
    big_d    = big_q;
    lz_d     = lz_q;
    op_sub_d = op_sub_q;
    zero_d   = zero_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_EXP;
          op_sub_d = op_sub;
          zero_d   = 1'b0;
        end
      end
      S_EXP:   state_d = S_ALIGN;
      S_ALIGN: begin
        state_d = S_EXP_SET;
        diff_d  = saida_registrador;
        big_d   = data_out_big_ula;
      end
      S_EXP_SET: begin
        state_d = S_EXP_LOAD;
        lz_d    = clz26(big_q);
      end
      S_EXP_LOAD: begin
        if (lz_q == 5'd26) begin
          state_d = S_DONE;
          zero_d  = 1'b1;
        end else begin
          state_d = S_NORM_SET;
        end
      end
      S_NORM_SET:  state_d = S_NORM_LOAD;
      S_NORM_LOAD: state_d = S_ROUND;
      S_ROUND:     state_d = overflow ? S_FIX_SET : S_DONE;
      S_FIX_SET:   state_d = S_FIX_LOAD;
      S_FIX_LOAD:  state_d = S_DONE;
      S_DONE:      state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase

    // Controls are decoded from the next state so the registers present them
    // during the cycle the FSM actually sits in that state.
    tamanho2_d  = 5'd0;
    tamanho3_d  = 8'd0;
    mux_exp_d   = 1'b0;
    mux_saida_d = 1'b0;
    dir_d       = 1'b0;
    sub_exp_d   = 1'b0;
    load_d      = 1'b0;
    done_d      = 1'b0;
    busy_d      = (state_d != S_IDLE);
    soma_d      = busy_d;
    case (state_d)
      S_EXP_SET, S_EXP_LOAD: begin
        tamanho3_d = diff_d;
        load_d     = (state_d == S_EXP_LOAD);
      end
      S_NORM_SET, S_NORM_LOAD, S_ROUND: begin
        mux_exp_d = 1'b1;
        if (lz_d == 5'd0) begin
          tamanho2_d = 5'd1;
          tamanho3_d = 8'd1;
        end else begin
          dir_d      = 1'b1;
          tamanho2_d = 5'(lz_d - 5'd1);
          tamanho3_d = {3'b000, 5'(lz_d - 5'd1)};
          sub_exp_d  = 1'b1;
        end
        load_d = (state_d == S_NORM_LOAD);
      end
      S_FIX_SET, S_FIX_LOAD: begin
        mux_saida_d = 1'b1;
        tamanho2_d  = 5'd1;
        mux_exp_d   = 1'b1;
        tamanho3_d  = 8'd1;
        load_d      = (state_d == S_FIX_LOAD);
      end
      S_DONE:  done_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      diff_q      <= 8'd0;
      big_q       <= 26'd0;
      lz_q        <= 5'd0;
      op_sub_q    <= 1'b0;
      zero_q      <= 1'b0;
      tamanho2_q  <= 5'd0;
      tamanho3_q  <= 8'd0;
      soma_q      <= 1'b0;
      mux_exp_q   <= 1'b0;
      mux_saida_q <= 1'b0;
      dir_q       <= 1'b0;
      sub_exp_q   <= 1'b0;
      load_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      diff_q      <= diff_d;
      big_q       <= big_d;
      lz_q        <= lz_d;
      op_sub_q    <= op_sub_d;
      zero_q      <= zero_d;
      tamanho2_q  <= tamanho2_d;
      tamanho3_q  <= tamanho3_d;
      soma_q      <= soma_d;
      mux_exp_q   <= mux_exp_d;
      mux_saida_q <= mux_saida_d;
      dir_q       <= dir_d;
      sub_exp_q   <= sub_exp_d;
      load_q      <= load_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // The exponent difference only becomes valid in ALIGN, so the shift amount
  // follows the datapath register directly while in that state.
  always_comb begin
    tamanho = 5'd0;
    if (state_q == S_ALIGN)
      tamanho = (saida_registrador > 8'd31) ? 5'd31 : saida_registrador[4:0];
  end

  assign tamanho2                       = tamanho2_q;
  assign tamanho3                       = tamanho3_q;
  assign soma_multiplica_small_ula      = soma_q;
  assign soma_multiplica_big_ula        = soma_q;
  assign decisor_mux_expoente_escolhido = mux_exp_q;
  assign decisor_mux_saida_big_ula      = mux_saida_q;
  assign decisor_shift_right_left       = dir_q;
  assign subtrador_big_ula              = op_sub_q;
  assign subtrador_Somador_subtrador    = sub_exp_q;
  assign load                           = load_q;
  assign busy                           = busy_q;
  assign done                           = done_q;
  assign zero_result                    = zero_q;

endmodule

// File: tb/tb_fp_add_controller.sv
// Bench for fp_add_controller: directed and random operations against a
// cycle-by-cycle reference schedule derived from the operation's inputs.
module tb_fp_add_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        op_sub = 1'b0;
  logic [7:0]  saida_registrador = 8'd0;
  logic [25:0] data_out_big_ula = 26'd0;
  logic        overflow = 1'b0;
  logic [4:0]  tamanho, tamanho2;
  logic [7:0]  tamanho3;
  logic        soma_s, soma_b, mux_exp, mux_saida, shift_dir, sub_big, sub_exp;
  logic        load, busy, done, zero_result;

  int total = 0;
  int bad = 0;

  typedef struct packed {
    logic [4:0] t1;
    logic [4:0] t2;
    logic [7:0] t3;
    logic ss, sb, mexp, msai, dir, subb, subss, ld, bsy, dn;
  } outv_t;

  outv_t act;
  assign act = {tamanho, tamanho2, tamanho3, soma_s, soma_b, mux_exp, mux_saida,
                shift_dir, sub_big, sub_exp, load, busy, done};

  fp_add_controller dut (
    .clk(clk), .reset(reset), .start(start), .op_sub(op_sub),
    .saida_registrador(saida_registrador), .data_out_big_ula(data_out_big_ula),
    .overflow(overflow), .tamanho(tamanho), .tamanho2(tamanho2), .tamanho3(tamanho3),
    .soma_multiplica_small_ula(soma_s), .soma_multiplica_big_ula(soma_b),
    .decisor_mux_expoente_escolhido(mux_exp), .decisor_mux_saida_big_ula(mux_saida),
    .decisor_shift_right_left(shift_dir), .subtrador_big_ula(sub_big),
    .subtrador_Somador_subtrador(sub_exp), .load(load), .busy(busy), .done(done),
    .zero_result(zero_result)
  );

  always #5 clk = ~clk;

  // One operation; poke > 0 pulses start (with op_sub flipped) during that cycle.
  task automatic run_op(input logic [7:0] saida, input logic [25:0] big, input logic ovf,
                        input logic ob, input int poke, input string name);
    int lz, lat, nload, nload_exp;
    logic [25:0] tmp;
    bit zr;
    outv_t e, m;
    logic [27:0] av, ev, mv;
    lz = 26;
    tmp = big;
    while (tmp != 0) begin
      tmp = tmp >> 1;
      lz--;
    end
    zr = (big == 26'd0);
    lat = zr ? 5 : (ovf ? 10 : 8);
    nload_exp = zr ? 1 : (ovf ? 3 : 2);
    nload = 0;
    @(negedge clk);
    saida_registrador = saida;
    data_out_big_ula  = big;
    overflow          = ovf;
    op_sub            = ob;
    start             = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c <= lat; c++) begin
      @(negedge clk);
      e = '0; m = '0;
      m.bsy = 1; m.ld = 1; m.dn = 1; m.ss = 1; m.sb = 1; m.subb = 1;
      e.bsy = 1; e.ss = 1; e.sb = 1; e.subb = ob;
      e.dn = (c == lat);
      e.ld = (c == 4) || (!zr && c == 6) || (!zr && ovf && c == 9);
      if (c == 2) begin
        m.t1 = '1;
        e.t1 = (saida > 8'd31) ? 5'd31 : saida[4:0];
      end
      if (c == 3 || c == 4) begin
        m.mexp = 1; m.subss = 1; m.t3 = '1;
        e.t3 = saida;
      end
      if (!zr && c >= 5 && c <= 7) begin
        m.mexp = 1; m.msai = 1; m.dir = 1; m.t2 = '1; m.t3 = '1; m.subss = 1;
        e.mexp = 1;
        if (lz == 0) begin
          e.dir = 0; e.t2 = 5'd1; e.t3 = 8'd1; e.subss = 0;
        end else begin
          e.dir = 1; e.t2 = 5'(lz - 1); e.t3 = 8'(lz - 1); e.subss = 1;
        end
      end
      if (!zr && ovf && (c == 8 || c == 9)) begin
        m.mexp = 1; m.msai = 1; m.dir = 1; m.t2 = '1; m.t3 = '1; m.subss = 1;
        e.msai = 1; e.dir = 0; e.t2 = 5'd1; e.mexp = 1; e.t3 = 8'd1; e.subss = 0;
      end
      av = act; ev = e; mv = m;
      total++;
      if ((av & mv) !== (ev & mv)) begin
        bad++;
        $display("FAIL %s cycle %0d outputs: got %h want %h", name, c, av & mv, ev & mv);
      end
      if (load) nload++;
      if (c == lat) begin
        total++;
        if (zero_result !== zr) begin
          bad++;
          $display("FAIL %s zero_result at done: got %b want %b", name, zero_result, zr);
        end
      end
      if (c == poke + 1) start = 1'b0;
      if (c == poke) begin
        start = 1'b1;
        op_sub = ~ob;
      end
    end
    start = 1'b0;
    @(negedge clk);
    total++;
    if ({busy, done, load, zero_result} !== {1'b0, 1'b0, 1'b0, zr}) begin
      bad++;
      $display("FAIL %s idle after done {busy,done,load,zero}: got %b want %b",
               name, {busy, done, load, zero_result}, {3'b000, zr});
    end
    total++;
    if (nload !== nload_exp) begin
      bad++;
      $display("FAIL %s load pulse count: got %0d want %0d", name, nload, nload_exp);
    end
    $display("op %s saida=%0d big=%h ovf=%b sub=%b lz=%0d latency=%0d loads=%0d",
             name, saida, big, ovf, ob, lz, lat, nload);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if ({act, zero_result} !== 29'd0) begin
      bad++;
      $display("FAIL reset outputs: got %h want 0", {act, zero_result});
    end
    reset = 1'b0;
    $display("reset check outputs=%h", {act, zero_result});
  endtask

  task automatic test_basic();
    run_op(8'd3, 26'h0400000, 1'b0, 1'b0, 0, "basic_lz3");
    run_op(8'd3, 26'h0400000, 1'b0, 1'b1, 0, "basic_sub");
  endtask

  task automatic test_big_diff();
    run_op(8'd40, 26'h0100000, 1'b0, 1'b0, 0, "diff40");
  endtask

  task automatic test_lz0();
    run_op(8'd5, 26'h2000001, 1'b0, 1'b0, 0, "lz0");
  endtask

  task automatic test_fix();
    run_op(8'd2, 26'h0800000, 1'b1, 1'b0, 0, "fix");
    run_op(8'd0, 26'h0000001, 1'b1, 1'b1, 0, "fix_lz25");
  endtask

  task automatic test_zero();
    run_op(8'd7, 26'h0000000, 1'b1, 1'b0, 0, "zero");
  endtask

  task automatic test_busy_start();
    run_op(8'd3, 26'h0400000, 1'b0, 1'b0, 3, "busy_poke3");
    run_op(8'd1, 26'h2000000, 1'b1, 1'b1, 7, "busy_poke7");
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    saida_registrador = 8'd3;
    data_out_big_ula  = 26'h0400000;
    overflow          = 1'b0;
    start             = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (6) @(negedge clk);
    total++;
    if (load !== 1'b1) begin
      bad++;
      $display("FAIL reset_mid load in NORM_LOAD: got %b want 1", load);
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if ({act, zero_result} !== 29'd0) begin
      bad++;
      $display("FAIL reset_mid outputs after reset edge: got %h want 0", {act, zero_result});
    end
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      total++;
      if ({busy, done, load} !== 3'b000) begin
        bad++;
        $display("FAIL reset_mid after release cycle %0d {busy,done,load}: got %b want 000",
                 c, {busy, done, load});
      end
    end
    $display("reset_mid done");
  endtask

  task automatic test_back_to_back();
    int c;
    @(negedge clk);
    saida_registrador = 8'd3;
    data_out_big_ula  = 26'h0400000;
    overflow          = 1'b0;
    op_sub            = 1'b0;
    start             = 1'b1;
    @(posedge clk);
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!done && c < 20);
    total++;
    if (c !== 8) begin
      bad++;
      $display("FAIL b2b first latency: got %0d want 8", c);
    end
    @(negedge clk);
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL b2b idle gap busy: got %b want 0", busy);
    end
    @(negedge clk);
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL b2b re-accept busy: got %b want 1", busy);
    end
    start = 1'b0;
    c = 1;
    while (!done && c < 20) begin
      @(negedge clk);
      c++;
    end
    total++;
    if (c !== 8) begin
      bad++;
      $display("FAIL b2b second latency: got %0d want 8", c);
    end
    @(negedge clk);
    $display("b2b second latency=%0d", c);
  endtask

  task automatic test_random();
    logic [25:0] big;
    int lat;
    for (int i = 0; i < 25; i++) begin
      big = 26'($urandom) >> $urandom_range(0, 26);
      lat = (big == 0) ? 5 : 8;
      run_op(8'($urandom), big, 1'($urandom), 1'($urandom),
             ($urandom_range(0, 1) != 0) ? $urandom_range(2, lat - 2) : 0, "random");
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_big_diff();
    test_lz0();
    test_fix();
    test_zero();
    test_busy_start();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
